// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the LFSR-based random number blocks.
//   fsm_t      : request FSM states (IDLE / SEARCH / DONE)
//   TAP_TABLE  : XNOR-Fibonacci tap masks for register widths 4..16.
//                Bit n of a mask set means register bit n feeds the feedback.
//                Every entry gives a maximal-length sequence (2^W - 1 states),
//                with the all-ones state as the single lock-up value.
//   all_ones() : all-ones pattern for a given width, i.e. the forbidden state
// -----------------------------------------------------------------------------
package prng_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } fsm_t;

   localparam int MIN_WIDTH = 4;
   localparam int MAX_WIDTH = 16;

   localparam logic [15:0] TAP_TABLE [MIN_WIDTH:MAX_WIDTH] = '{
      16'h000C,   //  4: bits 3,2
      16'h0014,   //  5: bits 4,2
      16'h0030,   //  6: bits 5,4
      16'h0060,   //  7: bits 6,5
      16'h00B8,   //  8: bits 7,5,4,3
      16'h0110,   //  9: bits 8,4
      16'h0240,   // 10: bits 9,6
      16'h0500,   // 11: bits 10,8
      16'h0829,   // 12: bits 11,5,3,0
      16'h100D,   // 13: bits 12,3,2,0
      16'h2015,   // 14: bits 13,4,2,0
      16'h6000,   // 15: bits 14,13
      16'hD008    // 16: bits 15,14,12,3
   };

   function automatic logic [15:0] all_ones(input int width);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < width) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// One combinational step of a Fibonacci XNOR LFSR. The register shifts left
// and the XNOR of the tapped bits enters at bit 0.
//   WIDTH : register width (4..16), selects the taps from TAP_TABLE
//   state : current register value
//   next  : register value after one step
// -----------------------------------------------------------------------------
import prng_pkg::*;

module lfsr_step #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next
);

   localparam logic [15:0] MASK = TAP_TABLE[WIDTH];

   logic [WIDTH-1:0] tapped;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_tap
         assign tapped[gi] = MASK[gi] ? state[gi] : 1'b0;
      end
   endgenerate

   // Every mask has an even tap count, so the reduction XNOR equals the
   // chained XNOR of the taps and maps all-ones onto itself (the lock-up).
   assign next = {state[WIDTH-2:0], ~^tapped};

endmodule

// File: rtl/prng_lfsr.sv
// -----------------------------------------------------------------------------
// prng_lfsr
// Free-running / on-demand LFSR random source with a bounded-value request
// port. A request searches the LFSR sequence, stepping once per cycle, until
// the register holds a value below the latched limit, then delivers it.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   en     : step the LFSR once per cycle while high
//   load   : load seed (all-ones seed is replaced by zero, lockup pulses)
//   seed   : value to load
//   req    : request one bounded value (accepted only in IDLE)
//   limit  : exclusive bound, latched on acceptance; 0 = full range
//   state  : current LFSR register
//   rnd    : last delivered value, held until the next delivery
//   valid  : one-cycle pulse with each new rnd
//   busy   : request in progress (SEARCH or DONE)
//   lockup : one-cycle pulse after an all-ones seed was corrected
// -----------------------------------------------------------------------------
import prng_pkg::*;

module prng_lfsr #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             req,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] rnd,
   output logic             valid,
   output logic             busy,
   output logic             lockup
);

   generate
      if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
         $error("prng_lfsr: WIDTH must be in 4..16");
      end
   endgenerate

   localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

   fsm_t             fsm_reg, fsm_next;
   logic [WIDTH-1:0] lfsr_reg, lfsr_next;
   logic [WIDTH-1:0] rnd_reg;
   logic [WIDTH-1:0] limit_reg;
   logic             lockup_reg;
   logic [WIDTH-1:0] step_value;
   logic             hit;
   logic             do_step;
   logic             seed_bad;

   lfsr_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .state (lfsr_reg),
      .next  (step_value)
   );

   assign hit      = (limit_reg == '0) || (lfsr_reg < limit_reg);
   assign seed_bad = (seed == ONES);
   // en and an unsatisfied search share one step; a hit holds the value
   // so the delivered rnd matches state in the DONE cycle.
   assign do_step  = en || ((fsm_reg == SEARCH) && !hit);

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_reg <= IDLE;
      end else begin
         fsm_reg <= fsm_next;
      end
   end

   // FSM next state
   always_comb begin
      fsm_next = fsm_reg;
      case (fsm_reg)
         IDLE:    if (req) fsm_next = SEARCH;
         SEARCH: begin
            if (load)     fsm_next = IDLE;   // load aborts the request
            else if (hit) fsm_next = DONE;
         end
         DONE:    fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      valid = (fsm_reg == DONE);
      busy  = (fsm_reg != IDLE);
   end

   // LFSR register update: load wins over stepping
   always_comb begin
      lfsr_next = lfsr_reg;
      if (load) begin
         lfsr_next = seed_bad ? '0 : seed;
      end else if (do_step) begin
         lfsr_next = step_value;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_reg   <= '0;
         rnd_reg    <= '0;
         limit_reg  <= '0;
         lockup_reg <= 1'b0;
      end else begin
         lfsr_reg   <= lfsr_next;
         lockup_reg <= load && seed_bad;
         if (fsm_reg == IDLE && req) begin
            limit_reg <= limit;
         end
         if (fsm_reg == SEARCH && !load && hit) begin
            rnd_reg <= lfsr_reg;
         end
      end
   end

   assign state  = lfsr_reg;
   assign rnd    = rnd_reg;
   assign lockup = lockup_reg;

endmodule
